// File: rtl/tug_match_referee.sv
// tug_match_referee
//   Match referee for the tug-of-war game. It watches both ends of the playfield
//   and the two press pulses, awards round points, and pulses round_restart so
//   the playfield recentres after each point. It declares a winner once a player
//   reaches WIN_COUNT points and holds in match-over until new_game is asserted.
//
//   Optional feature: TUG_SERVE_LOCK_EN. When this macro is defined, the block
//   holds in a lock state after every round end until both L and R are low.
//
// Ports
//   Clock, Reset   clock and asynchronous active-high reset
//   field          playfield lights; field[PF_WIDTH-1] is the P1 end, field[0]
//                  is the P2 end
//   L, R           P1 and P2 press pulses, already synchronised
//   new_game       restart request, acted on only while the match is over
//   round_restart  one-cycle recentre pulse
//   match_over     high while the match is over
//   winner         00 none, 01 P1, 10 P2
//   hex_p1/hex_p2  active-low score digits
//   hex_win        active-low winner digit (1, 2 or blank)
module tug_match_referee #(
  parameter int unsigned PF_WIDTH  = 9,
  parameter int unsigned WIN_COUNT = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [PF_WIDTH-1:0] field,
  input  logic                L,
  input  logic                R,
  input  logic                new_game,
  output logic                round_restart,
  output logic                match_over,
  output logic [1:0]          winner,
  output logic [6:0]          hex_p1,
  output logic [6:0]          hex_p2,
  output logic [6:0]          hex_win
);

  localparam logic [3:0] WinCnt = 4'(WIN_COUNT);
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {
    StPlay      = 2'd0,
    StRoundEnd  = 2'd1,
`ifdef TUG_SERVE_LOCK_EN
    StLock      = 2'd2,
`endif
    StMatchOver = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;

  logic p1_pt, p2_pt;

  // Only the two end lights matter; the middle of the field is ignored.
  if (PF_WIDTH > 2) begin : g_mid
    logic unused_field_mid;
    assign unused_field_mid = ^field[PF_WIDTH-2:1];
  end

  assign p1_pt = field[PF_WIDTH-1] & L & ~R;
  assign p2_pt = field[0] & R & ~L;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    unique case (state_q)
      StPlay: begin
        if (p1_pt) begin
          score1_d = score1_q + 4'd1;
          if (score1_d == WinCnt) begin
            state_d  = StMatchOver;
            winner_d = 2'b01;
          end else begin
            state_d = StRoundEnd;
          end
        end else if (p2_pt) begin
          score2_d = score2_q + 4'd1;
          if (score2_d == WinCnt) begin
            state_d  = StMatchOver;
            winner_d = 2'b10;
          end else begin
            state_d = StRoundEnd;
          end
        end
      end
      StRoundEnd: begin
`ifdef TUG_SERVE_LOCK_EN
        state_d = StLock;
`else
        state_d = StPlay;
`endif
      end
`ifdef TUG_SERVE_LOCK_EN
      StLock: begin
        if (!L && !R) begin
          state_d = StPlay;
        end
      end
`endif
      StMatchOver: begin
        if (new_game) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          state_d  = StRoundEnd;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StPlay;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Outputs are decoded purely from registered state.
  always_comb begin
    round_restart = (state_q == StRoundEnd);
    match_over    = (state_q == StMatchOver);
    winner        = winner_q;
    hex_p1        = seg7(score1_q);
    hex_p2        = seg7(score2_q);
    case (winner_q)
      2'b01:   hex_win = seg7(4'd1);
      2'b10:   hex_win = seg7(4'd2);
      default: hex_win = SegBlank;
    endcase
  end

endmodule

// File: tb/tb_tug_match_referee.sv
module tb_tug_match_referee;

  localparam int W   = 9;
  localparam int WIN = 3;
`ifdef TUG_SERVE_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] field;
  logic         L, R, new_game;
  logic         round_restart, match_over;
  logic [1:0]   winner;
  logic [6:0]   hex_p1, hex_p2, hex_win;

  int errors = 0;
  int checks = 0;

  tug_match_referee #(.PF_WIDTH(W), .WIN_COUNT(WIN)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .field        (field),
    .L            (L),
    .R            (R),
    .new_game     (new_game),
    .round_restart(round_restart),
    .match_over   (match_over),
    .winner       (winner),
    .hex_p1       (hex_p1),
    .hex_p2       (hex_p2),
    .hex_win      (hex_win)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: scores as integers, a few flags for the match phase.
  int m_s1, m_s2, m_win;
  bit m_over, m_rr, m_lock;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_s1 <= 0; m_s2 <= 0; m_win <= 0;
      m_over <= 0; m_rr <= 0; m_lock <= 0;
    end else if (m_over) begin
      if (new_game) begin
        m_s1 <= 0; m_s2 <= 0; m_win <= 0;
        m_over <= 0; m_rr <= 1;
      end
    end else if (m_rr) begin
      m_rr   <= 0;
      m_lock <= LockEn;
    end else if (m_lock) begin
      if (!L && !R) m_lock <= 0;
    end else begin
      if (field[W-1] && L && !R) begin
        m_s1 <= m_s1 + 1;
        if (m_s1 + 1 == WIN) begin m_over <= 1; m_win <= 1; end
        else m_rr <= 1;
      end else if (field[0] && R && !L) begin
        m_s2 <= m_s2 + 1;
        if (m_s2 + 1 == WIN) begin m_over <= 1; m_win <= 2; end
        else m_rr <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] win_digit(input int w);
    return (w == 1) ? SEG[1] : (w == 2) ? SEG[2] : BLANK;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    chk("round_restart", {6'd0, round_restart}, {6'd0, m_rr});
    chk("match_over", {6'd0, match_over}, {6'd0, m_over});
    chk("winner", {5'd0, winner}, 7'(m_win));
    chk("hex_p1", hex_p1, SEG[m_s1]);
    chk("hex_p2", hex_p2, SEG[m_s2]);
    chk("hex_win", hex_win, win_digit(m_win));
  end

  task automatic drive(input logic [W-1:0] f, input logic l, input logic r, input logic ng);
    @(negedge Clock);
    field = f; L = l; R = r; new_game = ng;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_round_restart", {6'd0, round_restart}, 7'd0);
    chk("rst_match_over", {6'd0, match_over}, 7'd0);
    chk("rst_winner", {5'd0, winner}, 7'd0);
    chk("rst_hex_p1", hex_p1, 7'b1000000);
    chk("rst_hex_p2", hex_p2, 7'b1000000);
    chk("rst_hex_win", hex_win, 7'b1111111);
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic mid_reset();
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 chk_reset_vals();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    field = '0; L = 0; R = 0; new_game = 0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk_reset_vals();
    Reset = 1'b0;
    idle(2);

    // P1 point.
    drive(9'b100000000, 1'b1, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("p1_hex", hex_p1, 7'b1111001);
    chk("p1_rr", {6'd0, round_restart}, 7'd1);
    chk("p1_mo", {6'd0, match_over}, 7'd0);
    idle(3);

    // Simultaneous presses, then wrong end.
    drive(9'b100000001, 1'b1, 1'b1, 1'b0);
    drive(9'b000000001, 1'b1, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("both_hex_p1", hex_p1, 7'b1111001);
    chk("both_hex_p2", hex_p2, 7'b1000000);
    chk("both_rr", {6'd0, round_restart}, 7'd0);
    idle(2);

    // Three P2 points win the match.
    for (int i = 0; i < 3; i++) begin
      drive(9'b000000001, 1'b0, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b0, 1'b0);
      if (i < 2) idle(2);
    end
    chk("win_hex_p2", hex_p2, 7'b0110000);
    chk("win_winner", {5'd0, winner}, 7'b0000010);
    chk("win_hex_win", hex_win, 7'b0100100);
    chk("win_mo", {6'd0, match_over}, 7'd1);
    chk("win_rr", {6'd0, round_restart}, 7'd0);
    drive(9'b100000001, 1'b1, 1'b0, 1'b0);
    drive(9'b100000001, 1'b0, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("frozen_p1", hex_p1, 7'b1111001);
    chk("frozen_p2", hex_p2, 7'b0110000);

    // New game.
    drive('0, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("ng_p1", hex_p1, 7'b1000000);
    chk("ng_p2", hex_p2, 7'b1000000);
    chk("ng_winner", {5'd0, winner}, 7'd0);
    chk("ng_rr", {6'd0, round_restart}, 7'd1);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("ng_rr_end", {6'd0, round_restart}, 7'd0);
    idle(2);

    // Held R across the round end.
    drive(9'b000000001, 1'b0, 1'b1, 1'b0);
    drive(9'b000000001, 1'b0, 1'b1, 1'b0);
    drive(9'b000000001, 1'b0, 1'b1, 1'b0);
    drive(9'b000000001, 1'b0, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
`ifdef TUG_SERVE_LOCK_EN
    chk("lock_hex_p2", hex_p2, 7'b1111001);
    chk("lock_rr", {6'd0, round_restart}, 7'd0);
    drive(9'b000000001, 1'b0, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0, 1'b0);
    chk("unlock_hex_p2", hex_p2, 7'b0100100);
`endif
    idle(3);

    mid_reset();
    idle(2);

    // Randomised phase; field ends are biased to be lit so points happen.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] f;
      f = W'($urandom);
      if ($urandom_range(0, 1) == 0) f[W-1] = 1'b1;
      if ($urandom_range(0, 1) == 0) f[0] = 1'b1;
      drive(f, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 499) == 0) mid_reset();
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
